// File: rtl/regfile_pkg.sv
// Purpose: shared defaults, the x0 address constant and operand typedefs for the RV32 register file.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package regfile_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_ADDR_WIDTH = 5;
    localparam int DEFAULT_NUM_REGS   = 32;

    // x0 is architecturally hardwired to zero
    localparam logic [DEFAULT_ADDR_WIDTH-1:0] ZERO_REG = 5'd0;

    typedef logic [DEFAULT_ADDR_WIDTH-1:0] reg_addr_t;
    typedef logic [DEFAULT_DATA_WIDTH-1:0] reg_data_t;

endpackage

// File: rtl/regfile_read_port.sv
// Purpose: one combinational read port: address mux with x0 masking, optional write-first forwarding (REGFILE_WRITE_BYPASS_EN).
// Latency: 0 cycles, output follows address and array contents.
// Backpressure: none; output is always valid.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int NUM_REGS   = DEFAULT_NUM_REGS
) (
    input  logic [ADDR_WIDTH-1:0] read_address,
    input  logic [DATA_WIDTH-1:0] regs [NUM_REGS],
`ifdef REGFILE_WRITE_BYPASS_EN
    input  logic                  write_enable,
    input  logic [ADDR_WIDTH-1:0] write_address,
    input  logic [DATA_WIDTH-1:0] write_data,
`endif
    output logic [DATA_WIDTH-1:0] read_data
);

    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(ZERO_REG);

    // Select the addressed register; x0 always reads zero, optionally forward the in-flight write
    always_comb begin
        read_data = '0;
        if (read_address != ZERO_ADDR) begin
            read_data = regs[read_address];
`ifdef REGFILE_WRITE_BYPASS_EN
            // write_address == read_address != 0 here, so x0 can never be forwarded
            if (write_enable && (write_address == read_address)) begin
                read_data = write_data;
            end
`endif
        end
    end

endmodule

// File: rtl/register_file.sv
// Purpose: RV32 integer register file, 32x32, two combinational read ports, one synchronous write port, x0 hardwired to zero.
// Latency: reads 0 cycles; writes visible after the next rising clk edge (same cycle when REGFILE_WRITE_BYPASS_EN is defined).
// Backpressure: none; every write is accepted and both read ports are always valid.
module register_file
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int NUM_REGS   = DEFAULT_NUM_REGS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] read_address1,
    input  logic [ADDR_WIDTH-1:0] read_address2,
    input  logic [ADDR_WIDTH-1:0] write_address,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  write_enable,
    output logic [DATA_WIDTH-1:0] read_data1,
    output logic [DATA_WIDTH-1:0] read_data2
);

    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(ZERO_REG);

    generate
        if (NUM_REGS != (2 ** ADDR_WIDTH)) begin : g_bad_size
            $error("register_file: NUM_REGS must equal 2**ADDR_WIDTH");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    // Storage: async clear of every register, then write the destination unless it is x0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (write_enable && (write_address != ZERO_ADDR)) begin
            regs[write_address] <= write_data;
        end
    end

    regfile_read_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_REGS   (NUM_REGS)
    ) u_read_port1 (
        .read_address  (read_address1),
        .regs          (regs),
`ifdef REGFILE_WRITE_BYPASS_EN
        .write_enable  (write_enable),
        .write_address (write_address),
        .write_data    (write_data),
`endif
        .read_data     (read_data1)
    );

    regfile_read_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_REGS   (NUM_REGS)
    ) u_read_port2 (
        .read_address  (read_address2),
        .regs          (regs),
`ifdef REGFILE_WRITE_BYPASS_EN
        .write_enable  (write_enable),
        .write_address (write_address),
        .write_data    (write_data),
`endif
        .read_data     (read_data2)
    );

endmodule

// File: tb/tb_register_file.sv
// Purpose: self-checking bench for register_file against an array reference model, directed scenarios plus random traffic.
// Latency: n/a.
// Backpressure: n/a.
module tb_register_file;

    logic        clk;
    logic        rst_n;
    logic [4:0]  read_address1;
    logic [4:0]  read_address2;
    logic [4:0]  write_address;
    logic [31:0] write_data;
    logic        write_enable;
    logic [31:0] read_data1;
    logic [31:0] read_data2;

    int tests_run;
    int tests_failed;

    // Reference model: plain array of architectural register values
    logic [31:0] model [32];

    register_file dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .read_address1 (read_address1),
        .read_address2 (read_address2),
        .write_address (write_address),
        .write_data    (write_data),
        .write_enable  (write_enable),
        .read_data1    (read_data1),
        .read_data2    (read_data2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected read value for the currently driven inputs
    function automatic logic [31:0] expect_read(input logic [4:0] addr);
        if (addr == 5'd0) return 32'h0;
        if (!rst_n) return 32'h0;
`ifdef REGFILE_WRITE_BYPASS_EN
        if (write_enable && (write_address == addr)) return write_data;
`endif
        return model[addr];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
    endtask

    // Drive inputs just after the falling edge, then let combinational reads settle
    task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [4:0] a1, input logic [4:0] a2);
        @(negedge clk);
        write_enable  = we;
        write_address = wa;
        write_data    = wd;
        read_address1 = a1;
        read_address2 = a2;
        #1;
    endtask

    // Advance across a rising edge and apply the architectural write rule to the model
    task automatic tick();
        @(posedge clk);
        if (rst_n && write_enable && (write_address != 5'd0)) model[write_address] = write_data;
        #1;
    endtask

    task automatic do_write(input logic [4:0] wa, input logic [31:0] wd);
        drive(1'b1, wa, wd, 5'd0, 5'd0);
        tick();
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        write_enable = 1'b0; write_address = '0; write_data = '0;
        read_address1 = '0; read_address2 = '0;
        model_clear();
        #3;
        for (int a = 0; a < 32; a += 7) begin
            read_address1 = 5'(a);
            read_address2 = 5'(31 - a);
            #1;
            tests_run++;
            if (read_data1 !== 32'h0 || read_data2 !== 32'h0) begin
                tests_failed++;
                $display("FAIL reset_state addr=%0d got %h/%h want 0/0", a, read_data1, read_data2);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_write_readback();
        do_write(5'd1, 32'hDEADBEEF);
        drive(1'b0, 5'd0, 32'h0, 5'd1, 5'd0);
        tests_run++;
        if (read_data1 !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("FAIL write_readback got %h want deadbeef", read_data1);
        end
    endtask

    task automatic test_x0();
        do_write(5'd0, 32'hFFFFFFFF);
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        tests_run++;
        if (read_data1 !== 32'h0 || read_data2 !== 32'h0) begin
            tests_failed++;
            $display("FAIL x0_hardwired got %h/%h want 0/0", read_data1, read_data2);
        end
        // Even with the write in flight, x0 must read zero
        drive(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
        tests_run++;
        if (read_data1 !== 32'h0 || read_data2 !== 32'h0) begin
            tests_failed++;
            $display("FAIL x0_inflight got %h/%h want 0/0", read_data1, read_data2);
        end
        tick();
    endtask

    task automatic test_disabled_write();
        drive(1'b0, 5'd2, 32'h12345678, 5'd2, 5'd2);
        tick();
        drive(1'b0, 5'd0, 32'h0, 5'd2, 5'd2);
        tests_run++;
        if (read_data1 !== 32'h0 || read_data2 !== 32'h0) begin
            tests_failed++;
            $display("FAIL disabled_write got %h/%h want 0/0", read_data1, read_data2);
        end
    endtask

    task automatic test_dual_port();
        do_write(5'd3, 32'hA5A5A5A5);
        do_write(5'd31, 32'h5A5A5A5A);
        drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd31);
        tests_run++;
        if (read_data1 !== 32'hA5A5A5A5 || read_data2 !== 32'h5A5A5A5A) begin
            tests_failed++;
            $display("FAIL dual_port got %h/%h want a5a5a5a5/5a5a5a5a", read_data1, read_data2);
        end
        drive(1'b0, 5'd0, 32'h0, 5'd31, 5'd31);
        tests_run++;
        if (read_data1 !== 32'h5A5A5A5A || read_data2 !== 32'h5A5A5A5A) begin
            tests_failed++;
            $display("FAIL dual_same_addr got %h/%h want 5a5a5a5a/5a5a5a5a", read_data1, read_data2);
        end
    endtask

    task automatic test_read_during_write();
        logic [31:0] pre_edge;
`ifdef REGFILE_WRITE_BYPASS_EN
        pre_edge = 32'h22222222;
`else
        pre_edge = 32'h11111111;
`endif
        do_write(5'd4, 32'h11111111);
        drive(1'b1, 5'd4, 32'h22222222, 5'd4, 5'd3);
        tests_run++;
        if (read_data1 !== pre_edge || read_data2 !== 32'hA5A5A5A5) begin
            tests_failed++;
            $display("FAIL rdw_pre_edge got %h/%h want %h/a5a5a5a5", read_data1, read_data2, pre_edge);
        end
        tick();
        drive(1'b0, 5'd0, 32'h0, 5'd4, 5'd4);
        tests_run++;
        if (read_data1 !== 32'h22222222 || read_data2 !== 32'h22222222) begin
            tests_failed++;
            $display("FAIL rdw_post_edge got %h/%h want 22222222/22222222", read_data1, read_data2);
        end
    endtask

    task automatic test_reset_midrun();
        for (int a = 1; a < 32; a++) do_write(5'(a), $urandom() | 32'h1);
        // Assert reset between edges and check before any rising edge arrives
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        model_clear();
        for (int a = 0; a < 32; a++) begin
            read_address1 = 5'(a);
            read_address2 = 5'(31 - a);
            #0.1;
            tests_run++;
            if (read_data1 !== 32'h0 || read_data2 !== 32'h0) begin
                tests_failed++;
                $display("FAIL reset_midrun addr=%0d got %h/%h want 0/0", a, read_data1, read_data2);
            end
        end
        // Write attempted while reset is held must be ignored
        drive(1'b1, 5'd9, 32'hCAFEF00D, 5'd9, 5'd9);
        tick();
        drive(1'b0, 5'd0, 32'h0, 5'd9, 5'd9);
        rst_n = 1'b1;
        #1;
        tests_run++;
        if (read_data1 !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_priority got %h want 0", read_data1);
        end
    endtask

    task automatic test_random();
        logic [31:0] e1;
        logic [31:0] e2;
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), $urandom(),
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            // Bias toward read-during-write collisions
            if ($urandom_range(0, 3) == 0) read_address1 = write_address;
            #1;
            e1 = expect_read(read_address1);
            e2 = expect_read(read_address2);
            tests_run++;
            if (read_data1 !== e1 || read_data2 !== e2) begin
                tests_failed++;
                $display("FAIL random n=%0d a1=%0d a2=%0d we=%0b wa=%0d got %h/%h want %h/%h",
                         n, read_address1, read_address2, write_enable, write_address,
                         read_data1, read_data2, e1, e2);
            end
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_write_readback();
        test_x0();
        test_disabled_write();
        test_dual_port();
        test_read_during_write();
        test_reset_midrun();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- General-purpose integer register file for the RV32 core: 32 x 32-bit registers, two combinational read ports, one synchronous write port.
- Sits between decode (source operand addresses) and writeback (destination write).
- Register x0 is hardwired to zero.

Parameters:
- DATA_WIDTH, 32, register width in bits.
- ADDR_WIDTH, 5, register address width.
- NUM_REGS, 32, number of architectural registers; must equal 2**ADDR_WIDTH.

Ports:
- clk  input  1  system clock; all writes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- read_address1  input  ADDR_WIDTH  address for read port 1 (rs1).
- read_address2  input  ADDR_WIDTH  address for read port 2 (rs2).
- write_address  input  ADDR_WIDTH  destination register (rd).
- write_data  input  DATA_WIDTH  data to write.
- write_enable  input  1  active-high write strobe, sampled on the rising clk edge.
- read_data1  output  DATA_WIDTH  contents of read_address1.
- read_data2  output  DATA_WIDTH  contents of read_address2.

Behaviour:
- Reset:
  - rst_n low asynchronously clears all registers to 0, regardless of clk.
  - read_data1/read_data2 therefore show 0 for any address while in reset and until written.
  - Reset has priority over any write in the same cycle.
  - Deassertion is synchronised externally; the block only requires rst_n to be high at the edge for a write to take effect.
- Write:
  - On a rising clk edge with rst_n high, write_enable=1 and write_address != 0, register[write_address] <= write_data.
  - Latency 1 cycle: new value is visible on read ports after that edge.
  - Writes to address 0 are discarded.
  - write_enable=0 leaves all registers unchanged.
- Read:
  - Purely combinational. read_dataN = 0 when read_addressN == 0, else register[read_addressN].
  - No clock latency; outputs follow address changes within the same cycle.
  - Both ports are independent; both may read the same address.
- Read-during-write, same address, same cycle: the read port returns the old (pre-edge) value unless the optional bypass feature is compiled in.
- X on unused inputs: read addresses are always decoded; there are no X-propagation requirements beyond the standard simulator semantics.

Optional Feature:
- Macro REGFILE_WRITE_BYPASS_EN.
- Defined: when write_enable=1, write_address != 0 and read_addressN == write_address, read_dataN returns write_data combinationally in the same cycle (write-first forwarding). Address 0 still reads 0.
- Undefined: read-during-write returns the stored value, which updates after the edge.

Decomposition:
- Shared package regfile_pkg holds:
  - DATA_WIDTH / ADDR_WIDTH / NUM_REGS defaults.
  - ZERO_REG address constant (5'd0).
  - Typedefs reg_addr_t and reg_data_t.
- One natural sub-module, regfile_read_port: a combinational address decode/mux with x0 masking and the optional bypass compare. Instantiate it twice.
- The storage array and write logic stay in register_file.

Test Plan:
- Reset: assert rst_n=0 mid-run after writes to x1..x31 -> all reads return 0x00000000 immediately, without a clock edge.
- Write/readback: write_address=1, write_data=0xDEADBEEF, write_enable=1 for one edge, then write_enable=0, read_address1=1 -> read_data1=0xDEADBEEF.
- x0 hardwired: write 0xFFFFFFFF to address 0 -> read_data1/read_data2 at address 0 = 0x00000000.
- Disabled write: write_enable=0, write_address=2, write_data=0x12345678 across an edge -> register 2 keeps its previous value (0 after reset).
- Dual port: x3=0xA5A5A5A5, x31=0x5A5A5A5A; read_address1=3, read_address2=31 -> both values correct simultaneously; then both ports at 31 -> both 0x5A5A5A5A.
- Read-during-write: x4=0x11111111, then write 0x22222222 to x4 while read_address1=4. Before the edge, read_data1=0x11111111 without bypass, or 0x22222222 with REGFILE_WRITE_BYPASS_EN. After the edge, 0x22222222 in both builds.
